// File: rtl/cpu_pkg.sv
// Shared CPU definitions: store-size encodings (also used by the load-extension path)
// and the store unit state encoding.
package cpu_pkg;

    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StWrite,
        StDone,
        StErr
    } store_state_e;

    // Reserved size, odd halfword, or any non-word-aligned word is rejected.
    function automatic logic store_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic bad;
        case (size)
            SZ_WORD: bad = (addr_lo != 2'b00);
            SZ_HALF: bad = addr_lo[0];
            SZ_BYTE: bad = 1'b0;
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/store_size_unit_if.sv
// Control handshake plus data-memory port of the store size unit.
interface store_size_unit_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              start;
    logic [1:0]        store_size;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       store_data;
    logic [31:0]       mem_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_wr;
    logic [31:0]       mem_wdata;
    logic              busy;
    logic              done;
    logic              align_err;

    // Control unit and memory side
    modport master (
        output start, store_size, addr, store_data, mem_rdata,
        input  mem_addr, mem_wr, mem_wdata, busy, done, align_err
    );

    // Store unit side
    modport slave (
        input  start, store_size, addr, store_data, mem_rdata,
        output mem_addr, mem_wr, mem_wdata, busy, done, align_err
    );
endinterface

// File: rtl/store_size_unit_lane_merge.sv
// Combinational lane merge: inserts the stored half/byte into the old memory word
// (little-endian lanes); word stores pass store_data straight through.
module store_lane_merge
    import cpu_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [31:0] store_data,
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    output logic [31:0] merged
);

    always_comb begin
        merged = old_word;
        case (size)
            SZ_WORD: merged = store_data;
            SZ_HALF: begin
                if (addr_lo[1]) merged[31:16] = store_data[15:0];
                else            merged[15:0]  = store_data[15:0];
            end
            SZ_BYTE: merged[{addr_lo, 3'b000} +: 8] = store_data[7:0];
            default: merged = old_word;
        endcase
    end

endmodule

// File: rtl/store_size_unit.sv
// Store size unit: word stores write directly, half/byte stores read-modify-write the
// addressed word. Start/done handshake toward control, synchronous memory port.
module store_size_unit
    import cpu_pkg::*;
#(
    parameter int unsigned MEM_LATENCY = 1,
    parameter int unsigned ADDR_W      = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    store_size_unit_if.slave   bus
);

    store_state_e      state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       data_q, data_d;
    logic [1:0]        size_q, size_d;
    logic [31:0]       merge_q, merge_d;
    logic [31:0]       merged;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= 3'd0;
            addr_q  <= '0;
            data_q  <= 32'd0;
            size_q  <= SZ_WORD;
            merge_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            size_q  <= size_d;
            merge_q <= merge_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        size_d  = size_q;
        merge_d = merge_q;
        case (state_q)
            StIdle: begin
                if (bus.start) begin
                    addr_d = bus.addr;
                    data_d = bus.store_data;
                    size_d = bus.store_size;
                    cnt_d  = 3'd0;
                    if (store_misaligned(bus.store_size, bus.addr[1:0])) state_d = StErr;
                    else if (bus.store_size == SZ_WORD)                  state_d = StWrite;
                    else                                                 state_d = StRead;
                end
            end
            StRead: begin
                // Address is held MEM_LATENCY+1 cycles; read data is valid on the last edge.
                if (cnt_q == 3'(MEM_LATENCY)) begin
                    merge_d = bus.mem_rdata;
                    state_d = StWrite;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            StWrite: state_d = StDone;
            StDone:  state_d = StIdle;
            StErr:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    store_lane_merge u_lane_merge (
        .old_word   (merge_q),
        .store_data (data_q),
        .size       (size_q),
        .addr_lo    (addr_q[1:0]),
        .merged     (merged)
    );

    assign bus.mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
    assign bus.mem_wdata = merged;
    assign bus.mem_wr    = (state_q == StWrite);
    assign bus.busy      = (state_q != StIdle);
    assign bus.done      = (state_q == StDone);
    assign bus.align_err = (state_q == StErr);

endmodule
